// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter for the mini-cpu fetch stage.
//
// Holds the current fetch address and selects the next one from a sequential
// step, a pc-relative branch, a JALR target, a trap vector or the saved
// exception pc (mret). Every computed redirect target is alignment-checked;
// a misaligned target parks the unit in FAULT (pc held, pc_valid low) until a
// trap with an aligned vector brings it back to RUN.
//
// Optional feature macro: PC_COMPRESSED_EN
//   defined   : insn_len16 port exists, sequential step is 2 or 4 bytes,
//               targets need only 2-byte alignment.
//   undefined : no insn_len16 port, step is always 4, 4-byte alignment.
//
// Parameters
//   XLEN          datapath / pc width in bits
//   RESET_VECTOR  pc value loaded on reset
//
// Ports
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   stall        in   hold pc this cycle (lower priority than trap/mret)
//   pc_src       in   00 pc+step, 01 pc+imm, 10 (rs1+imm)&~1, 11 = 00
//   imm          in   sign-extended immediate
//   rs1          in   jalr base register value
//   trap         in   redirect to trap_vector, save current pc to epc
//   trap_vector  in   trap handler address
//   mret         in   redirect to epc
//   insn_len16   in   current insn is 16 bits (PC_COMPRESSED_EN only)
//   pc           out  current fetch address
//   pc_valid     out  pc is a live fetch address
//   epc          out  saved exception pc
//   misaligned   out  sticky flag: last computed target was misaligned
//   state_dbg    out  FSM state (0 BOOT, 1 RUN, 2 FAULT) for observation
//
// Handshake: there is no valid/ready pair here. pc_valid is a pure
// qualifier: when high, pc is a fetch address the downstream stage may use
// this cycle; when low, pc must be ignored. Inputs are sampled every rising
// edge with no back-pressure.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret,
`ifdef PC_COMPRESSED_EN
    input  logic            insn_len16,
`endif
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JALR   = 2'b10;

    // Mask used to clear bit 0 of the jalr sum without leaving an unused bit.
    localparam logic [XLEN-1:0] JALR_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;

    // -----------------------------------------------------------------------
    // Target datapath
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;

`ifdef PC_COMPRESSED_EN
    assign step = insn_len16 ? XLEN'(2) : XLEN'(4);
`else
    assign step = XLEN'(4);
`endif

    // All adders wrap modulo 2^XLEN; carries out are intentionally dropped.
    assign seq_target  = pc_q + step;
    assign br_target   = pc_q + imm;
    assign jalr_sum    = rs1 + imm;
    assign jalr_target = jalr_sum & JALR_MASK;

    function automatic logic is_misaligned(input logic [XLEN-1:0] t);
`ifdef PC_COMPRESSED_EN
        return t[0];
`else
        return (t[1:0] != 2'b00);
`endif
    endfunction

    // RUN-state redirect selection: which target (if any) replaces pc.
    // Sequential steps are never misaligned because pc itself is aligned.
    logic            run_take;
    logic            run_check;
    logic            run_save_epc;
    logic [XLEN-1:0] run_target;

    always_comb begin
        run_take     = 1'b0;
        run_check    = 1'b0;
        run_save_epc = 1'b0;
        run_target   = pc_q;
        if (trap) begin
            run_take     = 1'b1;
            run_check    = 1'b1;
            run_save_epc = 1'b1;
            run_target   = trap_vector;
        end else if (mret) begin
            run_take   = 1'b1;
            run_check  = 1'b1;
            run_target = epc_q;
        end else if (!stall) begin
            run_take = 1'b1;
            unique case (pc_src)
                SRC_BRANCH: begin
                    run_check  = 1'b1;
                    run_target = br_target;
                end
                SRC_JALR: begin
                    run_check  = 1'b1;
                    run_target = jalr_target;
                end
                default: begin
                    // 00 and reserved 11 both step sequentially.
                    run_target = seq_target;
                end
            endcase
        end
    end

    logic run_fault;
    logic trap_vec_bad;

    assign run_fault    = run_take && run_check && is_misaligned(run_target);
    assign trap_vec_bad = is_misaligned(trap_vector);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        unique case (state_q)
            ST_BOOT: begin
                // One settling cycle after reset; every input is ignored.
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (run_fault) begin
                    // pc and epc stay put so the faulting context is visible.
                    state_d = ST_FAULT;
                    valid_d = 1'b0;
                    mis_d   = 1'b1;
                end else if (run_take) begin
                    pc_d = run_target;
                    if (run_save_epc) begin
                        epc_d = pc_q;
                    end
                end
            end
            ST_FAULT: begin
                // Only an aligned trap recovers; mret, stall and pc_src are dead.
                if (trap && !trap_vec_bad) begin
                    state_d = ST_RUN;
                    pc_d    = trap_vector;
                    epc_d   = pc_q;
                    valid_d = 1'b1;
                    mis_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers: asynchronous reset dominates any in-flight redirect.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = valid_q;
    assign epc        = epc_q;
    assign misaligned = mis_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam logic [63:0] RV2 = 64'hFFFF_FFFF_FFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rstn2 = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        stall = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [63:0] imm = '0;
  logic [63:0] rs1 = '0;
  logic        trap = 1'b0;
  logic [63:0] trap_vector = '0;
  logic        mret = 1'b0;
`ifdef PC_COMPRESSED_EN
  logic        insn_len16 = 1'b0;
`endif

  logic [63:0] pc, epc, pc2, epc2;
  logic        pc_valid, misaligned, pc_valid2, misaligned2;
  logic [1:0]  st, st2;

  pc_unit #(.XLEN(64), .RESET_VECTOR(64'h0)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .pc_src(pc_src), .imm(imm),
    .rs1(rs1), .trap(trap), .trap_vector(trap_vector), .mret(mret),
`ifdef PC_COMPRESSED_EN
    .insn_len16(insn_len16),
`endif
    .pc(pc), .pc_valid(pc_valid), .epc(epc), .misaligned(misaligned),
    .state_dbg(st)
  );

  pc_unit #(.XLEN(64), .RESET_VECTOR(RV2)) dut2 (
    .clk(clk), .rstn(rstn2), .stall(stall), .pc_src(pc_src), .imm(imm),
    .rs1(rs1), .trap(trap), .trap_vector(trap_vector), .mret(mret),
`ifdef PC_COMPRESSED_EN
    .insn_len16(insn_len16),
`endif
    .pc(pc2), .pc_valid(pc_valid2), .epc(epc2), .misaligned(misaligned2),
    .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the expected-queue head (pc, valid, epc, mis) against dut outputs.
  task automatic chk_dut(input string tag);
    logic [63:0] e_pc, e_v, e_epc, e_mis;
    e_pc = exp_q.pop_front();
    e_v = exp_q.pop_front();
    e_epc = exp_q.pop_front();
    e_mis = exp_q.pop_front();
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".valid"}, {63'b0, pc_valid}, e_v);
    chk({tag, ".epc"}, epc, e_epc);
    chk({tag, ".mis"}, {63'b0, misaligned}, e_mis);
  endtask

  task automatic expect4(input logic [63:0] p, input logic v, input logic [63:0] e, input logic m);
    exp_q.push_back(p);
    exp_q.push_back({63'b0, v});
    exp_q.push_back(e);
    exp_q.push_back({63'b0, m});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic t, input logic m, input logic [1:0] src,
                       input logic [63:0] i, input logic [63:0] r, input logic [63:0] tv);
    stall = s; trap = t; mret = m; pc_src = src; imm = i; rs1 = r; trap_vector = tv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0);
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        stall, trap, mret;
    logic [1:0]  src;
    logic [63:0] imm, rs1, tv;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [63:0] e_epc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic s, input logic t, input logic m,
                     input logic [1:0] src, input logic [63:0] i, input logic [63:0] r,
                     input logic [63:0] tv, input logic [63:0] ep, input logic ev,
                     input logic [63:0] ee, input logic em);
    vec_t v;
    v.name = n; v.stall = s; v.trap = t; v.mret = m; v.src = src; v.imm = i; v.rs1 = r;
    v.tv = tv; v.e_pc = ep; v.e_valid = ev; v.e_epc = ee; v.e_mis = em;
    vecs.push_back(v);
  endtask

  initial begin
    // --- table: tests 1-4 plus extra corners, starting at the BOOT edge ---
    //   name       st tr mr src imm                      rs1                     tv        pc                       v  epc       m
    add("boot",     0, 0, 0, 1, 64'd4,                   0,                      0,        64'h0,                   1, 64'h0,    0);
    add("seq4",     0, 0, 0, 0, 0,                       0,                      0,        64'd4,                   1, 64'h0,    0);
    add("seq8",     0, 0, 0, 0, 0,                       0,                      0,        64'd8,                   1, 64'h0,    0);
    add("seq12",    0, 0, 0, 0, 0,                       0,                      0,        64'd12,                  1, 64'h0,    0);
    add("seq16",    0, 0, 0, 0, 0,                       0,                      0,        64'd16,                  1, 64'h0,    0);
    add("seq20",    0, 0, 0, 0, 0,                       0,                      0,        64'd20,                  1, 64'h0,    0);
    add("br40",     0, 0, 0, 1, 64'd40,                  0,                      0,        64'd60,                  1, 64'h0,    0);
    add("seq64",    0, 0, 0, 0, 0,                       0,                      0,        64'd64,                  1, 64'h0,    0);
    add("seq68",    0, 0, 0, 0, 0,                       0,                      0,        64'd68,                  1, 64'h0,    0);
    add("brm64",    0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFC0, 0,                      0,        64'd4,                   1, 64'h0,    0);
    add("seq8b",    0, 0, 0, 0, 0,                       0,                      0,        64'd8,                   1, 64'h0,    0);
    add("stall1",   1, 0, 0, 1, 64'd100,                 0,                      0,        64'd8,                   1, 64'h0,    0);
    add("stall2",   1, 0, 0, 0, 0,                       0,                      0,        64'd8,                   1, 64'h0,    0);
    add("seq12b",   0, 0, 0, 0, 0,                       0,                      0,        64'd12,                  1, 64'h0,    0);
    add("jalr110",  0, 0, 0, 2, 64'h10,                  64'h101,                0,        64'h110,                 1, 64'h0,    0);
    add("seq114",   0, 0, 0, 0, 0,                       0,                      0,        64'h114,                 1, 64'h0,    0);
    add("jalrbad",  0, 0, 0, 2, 64'h0,                   64'h102,                0,        64'h114,                 0, 64'h0,    1);
    add("f_stall",  1, 0, 0, 0, 0,                       0,                      0,        64'h114,                 0, 64'h0,    1);
    add("f_mret",   0, 0, 1, 0, 0,                       0,                      0,        64'h114,                 0, 64'h0,    1);
    add("f_br",     0, 0, 0, 1, 64'd4,                   0,                      0,        64'h114,                 0, 64'h0,    1);
    add("f_trap",   0, 1, 0, 0, 0,                       0,                      64'h200,  64'h200,                 1, 64'h114,  0);
    add("jalr40",   0, 0, 0, 2, 64'h0,                   64'h40,                 0,        64'h40,                  1, 64'h114,  0);
    add("trapall",  1, 1, 1, 1, 64'd8,                   0,                      64'h80,   64'h80,                  1, 64'h40,   0);
    add("mret",     0, 0, 1, 0, 0,                       0,                      0,        64'h40,                  1, 64'h40,   0);
    add("seq44",    0, 0, 0, 0, 0,                       0,                      0,        64'h44,                  1, 64'h40,   0);
    add("br2bad",   0, 0, 0, 1, 64'd2,                   0,                      0,        64'h44,                  0, 64'h40,   1);
    add("f_trbad",  0, 1, 0, 0, 0,                       0,                      64'h302,  64'h44,                  0, 64'h40,   1);
    add("f_tr300",  0, 1, 0, 0, 0,                       0,                      64'h300,  64'h300,                 1, 64'h44,   0);
    add("jalrtop",  0, 0, 0, 2, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFC, 0,       64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h44,   0);
    add("wrap0",    0, 0, 0, 0, 0,                       0,                      0,        64'h0,                   1, 64'h44,   0);
    add("trbad",    0, 1, 0, 0, 0,                       0,                      64'h6,    64'h0,                   0, 64'h44,   1);
    add("f_tr10",   0, 1, 0, 0, 0,                       0,                      64'h10,   64'h10,                  1, 64'h0,    0);
    add("src11",    0, 0, 0, 3, 64'd40,                  0,                      0,        64'h14,                  1, 64'h0,    0);

    // --- test 1: reset held 4 cycles with a branch request present ---
    drive(1'b0, 1'b0, 1'b0, 2'b01, 64'd4, 64'h0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect4(64'h0, 1'b0, 64'h0, 1'b0);
      chk_dut("rst");
    end
    chk("rst2.pc", pc2, RV2);
    chk("rst2.valid", {63'b0, pc_valid2}, 64'h0);

    // release reset away from the edge
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].stall, vecs[k].trap, vecs[k].mret, vecs[k].src,
            vecs[k].imm, vecs[k].rs1, vecs[k].tv);
      tick();
      expect4(vecs[k].e_pc, vecs[k].e_valid, vecs[k].e_epc, vecs[k].e_mis);
      chk_dut(vecs[k].name);
    end
    idle();

    // --- test 5: top-of-range reset vector wraps, then async reset pulse ---
    @(negedge clk);
    rstn2 = 1'b1;
    tick();
    chk("rv.boot", pc2, RV2);
    chk("rv.bootv", {63'b0, pc_valid2}, 64'h1);
    tick();
    chk("rv.fc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("rv.wrap", pc2, 64'h0);
    tick();
    chk("rv.4", pc2, 64'h4);
    chk("rv.mis", {63'b0, misaligned2}, 64'h0);
    @(posedge clk);
    #3;
    rstn2 = 1'b0;
    #1;
    chk("rv.async.pc", pc2, RV2);
    chk("rv.async.v", {63'b0, pc_valid2}, 64'h0);
    rstn2 = 1'b1;

    // --- async reset of the main unit while a trap is being requested ---
    drive(1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h500);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    expect4(64'h0, 1'b0, 64'h0, 1'b0);
    chk_dut("async");
    tick();
    expect4(64'h0, 1'b0, 64'h0, 1'b0);
    chk_dut("async_hold");
    idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    expect4(64'h0, 1'b1, 64'h0, 1'b0);
    chk_dut("t6boot");

    // --- test 6: step size and alignment rule depend on the build ---
`ifdef PC_COMPRESSED_EN
    insn_len16 = 1'b1;
    tick();
    expect4(64'd2, 1'b1, 64'h0, 1'b0);
    chk_dut("c16a");
    tick();
    expect4(64'd4, 1'b1, 64'h0, 1'b0);
    chk_dut("c16b");
    insn_len16 = 1'b0;
    tick();
    expect4(64'd8, 1'b1, 64'h0, 1'b0);
    chk_dut("c32");
    drive(1'b0, 1'b0, 1'b0, 2'b01, 64'd6, 64'h0, 64'h0);
    tick();
    expect4(64'd14, 1'b1, 64'h0, 1'b0);
    chk_dut("cbr6");
`else
    tick();
    expect4(64'd4, 1'b1, 64'h0, 1'b0);
    chk_dut("n4");
    tick();
    expect4(64'd8, 1'b1, 64'h0, 1'b0);
    chk_dut("n8");
    drive(1'b0, 1'b0, 1'b0, 2'b01, 64'd6, 64'h0, 64'h0);
    tick();
    expect4(64'd8, 1'b0, 64'h0, 1'b1);
    chk_dut("nbr6");
`endif
    idle();
    chk("st.fault", {62'b0, st}, 
`ifdef PC_COMPRESSED_EN
        64'd1
`else
        64'd2
`endif
    );

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
